// File: rtl/wb_master_pkg.sv
// Shared state/status encodings and counter sizing for the Wishbone classic-cycle master bridge.
// Width fallbacks below mirror the shared parameter headers when those are not part of the compile.
`ifndef ADDR_WIDTH
`define ADDR_WIDTH 32
`endif
`ifndef DATA_WIDTH
`define DATA_WIDTH 32
`endif
`ifndef TGDI_WIDTH
`define TGDI_WIDTH 4
`endif
`ifndef TGDO_WIDTH
`define TGDO_WIDTH 4
`endif
`ifndef TGA_WIDTH
`define TGA_WIDTH 4
`endif
`ifndef TGC_WIDTH
`define TGC_WIDTH 4
`endif
`ifndef SEL_WIDTH
`define SEL_WIDTH 4
`endif

package wb_master_pkg;

  typedef enum logic [1:0] {
    ST_IDLE       = 2'd0,
    ST_BUS        = 2'd1,
    ST_RETRY_WAIT = 2'd2,
    ST_RESP       = 2'd3
  } wb_state_e;

  localparam logic [1:0] WB_ST_OK  = 2'b00;
  localparam logic [1:0] WB_ST_ERR = 2'b01;
  localparam logic [1:0] WB_ST_RTY = 2'b10;
  localparam logic [1:0] WB_ST_TMO = 2'b11;

  // Bits needed to count 0..max_val, never less than one.
  function automatic int cnt_width(input int max_val);
    return (max_val < 1) ? 1 : $clog2(max_val + 1);
  endfunction

endpackage

// File: rtl/wb_retry_timer.sv
// Retry and saturating timeout counters for one bus request; limit flags are combinational.
// tmo_expire_o is high in the bus cycle whose increment would reach TIMEOUT.
module wb_retry_timer
  import wb_master_pkg::*;
#(
  parameter int MAX_RETRY = 3,
  parameter int TIMEOUT   = 255
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic clr_i,
  input  logic tmo_clr_i,
  input  logic rty_inc_i,
  input  logic tmo_inc_i,
  output logic rty_limit_o,
  output logic tmo_expire_o
);

  localparam int RW = cnt_width(MAX_RETRY);
  localparam int TW = cnt_width(TIMEOUT);
  localparam logic [RW-1:0] RTY_MAX  = RW'(MAX_RETRY);
  localparam logic [TW-1:0] TMO_MAX  = TW'(TIMEOUT);
  localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT - 1);

  logic [RW-1:0] rty_cnt_d, rty_cnt_q;
  logic [TW-1:0] tmo_cnt_d, tmo_cnt_q;

  always_comb begin
    rty_cnt_d = rty_cnt_q;
    tmo_cnt_d = tmo_cnt_q;
    if (clr_i) begin
      rty_cnt_d = '0;
    end else if (rty_inc_i && (rty_cnt_q != RTY_MAX)) begin
      rty_cnt_d = rty_cnt_q + 1'b1;
    end
    if (clr_i || tmo_clr_i) begin
      tmo_cnt_d = '0;
    end else if (tmo_inc_i && (tmo_cnt_q != TMO_MAX)) begin
      tmo_cnt_d = tmo_cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      rty_cnt_q <= '0;
      tmo_cnt_q <= '0;
    end else begin
      rty_cnt_q <= rty_cnt_d;
      tmo_cnt_q <= tmo_cnt_d;
    end
  end

  assign rty_limit_o  = (rty_cnt_q == RTY_MAX);
  assign tmo_expire_o = (tmo_cnt_q >= TMO_LAST);

endmodule

// File: rtl/wb_master_bridge.sv
// Single-beat request -> Wishbone B4 classic cycle master with retry, timeout and tagged status response.
// Min latency 2 (accept edge to resp_valid_o); one request in flight, req_ready_o low until response is taken.
module wb_master_bridge
  import wb_master_pkg::*;
#(
  parameter int ADDR_WIDTH = `ADDR_WIDTH,
  parameter int DATA_WIDTH = `DATA_WIDTH,
  parameter int TGDI_WIDTH = `TGDI_WIDTH,
  parameter int TGDO_WIDTH = `TGDO_WIDTH,
  parameter int TGA_WIDTH  = `TGA_WIDTH,
  parameter int TGC_WIDTH  = `TGC_WIDTH,
  parameter int SEL_WIDTH  = `SEL_WIDTH,
  parameter int MAX_RETRY  = 3,
  parameter int TIMEOUT    = 255
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  req_valid_i,
  output logic                  req_ready_o,
  input  logic                  req_we_i,
  input  logic                  req_lock_i,
  input  logic [ADDR_WIDTH-1:0] req_adr_i,
  input  logic [DATA_WIDTH-1:0] req_dat_i,
  input  logic [SEL_WIDTH-1:0]  req_sel_i,
  input  logic [TGA_WIDTH-1:0]  req_tga_i,
  input  logic [TGC_WIDTH-1:0]  req_tgc_i,
  input  logic [TGDO_WIDTH-1:0] req_tgd_i,
  output logic                  resp_valid_o,
  input  logic                  resp_ready_i,
  output logic [DATA_WIDTH-1:0] resp_dat_o,
  output logic [TGDI_WIDTH-1:0] resp_tgd_o,
  output logic [1:0]            resp_status_o,
  output logic [ADDR_WIDTH-1:0] adr_o,
  output logic [DATA_WIDTH-1:0] dat_o,
  output logic [SEL_WIDTH-1:0]  sel_o,
  output logic                  we_o,
  output logic                  cyc_o,
  output logic                  stb_o,
  output logic                  lock_o,
  output logic [TGA_WIDTH-1:0]  tga_o,
  output logic [TGC_WIDTH-1:0]  tgc_o,
  output logic [TGDO_WIDTH-1:0] tgd_o,
  input  logic [DATA_WIDTH-1:0] dat_i,
  input  logic [TGDI_WIDTH-1:0] tgd_i,
  input  logic                  ack_i,
  input  logic                  err_i,
  input  logic                  rty_i
);

  wb_state_e state_d, state_q;

  logic                  we_d, we_q;
  logic                  lock_d, lock_q;
  logic [ADDR_WIDTH-1:0] adr_d, adr_q;
  logic [DATA_WIDTH-1:0] dat_d, dat_q;
  logic [SEL_WIDTH-1:0]  sel_d, sel_q;
  logic [TGA_WIDTH-1:0]  tga_d, tga_q;
  logic [TGC_WIDTH-1:0]  tgc_d, tgc_q;
  logic [TGDO_WIDTH-1:0] tgd_d, tgd_q;

  logic [DATA_WIDTH-1:0] resp_dat_d, resp_dat_q;
  logic [TGDI_WIDTH-1:0] resp_tgd_d, resp_tgd_q;
  logic [1:0]            resp_status_d, resp_status_q;

  logic cnt_clr, tmo_clr, rty_inc, tmo_inc;
  logic rty_limit, tmo_expire;

  wb_retry_timer #(
    .MAX_RETRY (MAX_RETRY),
    .TIMEOUT   (TIMEOUT)
  ) u_timer (
    .clk_i        (clk_i),
    .rst_i        (rst_i),
    .clr_i        (cnt_clr),
    .tmo_clr_i    (tmo_clr),
    .rty_inc_i    (rty_inc),
    .tmo_inc_i    (tmo_inc),
    .rty_limit_o  (rty_limit),
    .tmo_expire_o (tmo_expire)
  );

  always_comb begin
    state_d       = state_q;
    we_d          = we_q;
    lock_d        = lock_q;
    adr_d         = adr_q;
    dat_d         = dat_q;
    sel_d         = sel_q;
    tga_d         = tga_q;
    tgc_d         = tgc_q;
    tgd_d         = tgd_q;
    resp_dat_d    = resp_dat_q;
    resp_tgd_d    = resp_tgd_q;
    resp_status_d = resp_status_q;
    cnt_clr       = 1'b0;
    tmo_clr       = 1'b0;
    rty_inc       = 1'b0;
    tmo_inc       = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (req_valid_i) begin
          we_d          = req_we_i;
          lock_d        = req_lock_i;
          adr_d         = req_adr_i;
          dat_d         = req_dat_i;
          sel_d         = req_sel_i;
          tga_d         = req_tga_i;
          tgc_d         = req_tgc_i;
          tgd_d         = req_tgd_i;
          resp_dat_d    = '0;
          resp_tgd_d    = '0;
          resp_status_d = WB_ST_OK;
          cnt_clr       = 1'b1;
          state_d       = ST_BUS;
        end
      end
      ST_BUS: begin
        if (err_i) begin
          resp_status_d = WB_ST_ERR;
          state_d       = ST_RESP;
        end else if (ack_i) begin
          resp_dat_d    = we_q ? '0 : dat_i;
          resp_tgd_d    = tgd_i;
          resp_status_d = WB_ST_OK;
          state_d       = ST_RESP;
        end else if (rty_i) begin
          if (rty_limit) begin
            resp_status_d = WB_ST_RTY;
            state_d       = ST_RESP;
          end else begin
            rty_inc = 1'b1;
            state_d = ST_RETRY_WAIT;
          end
        end else begin
          tmo_inc = 1'b1;
          if (tmo_expire) begin
            resp_status_d = WB_ST_TMO;
            state_d       = ST_RESP;
          end
        end
      end
      ST_RETRY_WAIT: begin
        // Each new attempt gets a full timeout window.
        tmo_clr = 1'b1;
        state_d = ST_BUS;
      end
      ST_RESP: begin
        if (resp_ready_i) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      state_q       <= ST_IDLE;
      we_q          <= 1'b0;
      lock_q        <= 1'b0;
      adr_q         <= '0;
      dat_q         <= '0;
      sel_q         <= '0;
      tga_q         <= '0;
      tgc_q         <= '0;
      tgd_q         <= '0;
      resp_dat_q    <= '0;
      resp_tgd_q    <= '0;
      resp_status_q <= WB_ST_OK;
    end else begin
      state_q       <= state_d;
      we_q          <= we_d;
      lock_q        <= lock_d;
      adr_q         <= adr_d;
      dat_q         <= dat_d;
      sel_q         <= sel_d;
      tga_q         <= tga_d;
      tgc_q         <= tgc_d;
      tgd_q         <= tgd_d;
      resp_dat_q    <= resp_dat_d;
      resp_tgd_q    <= resp_tgd_d;
      resp_status_q <= resp_status_d;
    end
  end

  assign req_ready_o   = (state_q == ST_IDLE) && rst_i;
  assign cyc_o         = (state_q == ST_BUS);
  assign stb_o         = (state_q == ST_BUS);
  // Lock spans the retry gap so a locked sequence is not broken by a retry.
  assign lock_o        = lock_q && ((state_q == ST_BUS) || (state_q == ST_RETRY_WAIT));
  assign we_o          = we_q;
  assign adr_o         = adr_q;
  assign dat_o         = dat_q;
  assign sel_o         = sel_q;
  assign tga_o         = tga_q;
  assign tgc_o         = tgc_q;
  assign tgd_o         = tgd_q;
  assign resp_valid_o  = (state_q == ST_RESP);
  assign resp_dat_o    = resp_dat_q;
  assign resp_tgd_o    = resp_tgd_q;
  assign resp_status_o = resp_status_q;

endmodule

// File: tb/tb_wb_master_bridge.sv
// Directed bench for wb_master_bridge: read, waited write, retry exhaustion, timeout, err priority, mid-cycle reset.
module tb_wb_master_bridge;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        req_valid_i, req_ready_o, req_we_i, req_lock_i;
  logic [31:0] req_adr_i, req_dat_i;
  logic [3:0]  req_sel_i, req_tga_i, req_tgc_i, req_tgd_i;
  logic        resp_valid_o, resp_ready_i;
  logic [31:0] resp_dat_o;
  logic [3:0]  resp_tgd_o;
  logic [1:0]  resp_status_o;
  logic [31:0] adr_o, dat_o;
  logic [3:0]  sel_o, tga_o, tgc_o, tgd_o;
  logic        we_o, cyc_o, stb_o, lock_o;
  logic [31:0] dat_i;
  logic [3:0]  tgd_i;
  logic        ack_i, err_i, rty_i;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk_i = ~clk_i;

  wb_master_bridge #(
    .ADDR_WIDTH(32), .DATA_WIDTH(32), .TGDI_WIDTH(4), .TGDO_WIDTH(4),
    .TGA_WIDTH(4), .TGC_WIDTH(4), .SEL_WIDTH(4), .MAX_RETRY(3), .TIMEOUT(8)
  ) dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .req_valid_i(req_valid_i), .req_ready_o(req_ready_o), .req_we_i(req_we_i),
    .req_lock_i(req_lock_i), .req_adr_i(req_adr_i), .req_dat_i(req_dat_i),
    .req_sel_i(req_sel_i), .req_tga_i(req_tga_i), .req_tgc_i(req_tgc_i),
    .req_tgd_i(req_tgd_i), .resp_valid_o(resp_valid_o), .resp_ready_i(resp_ready_i),
    .resp_dat_o(resp_dat_o), .resp_tgd_o(resp_tgd_o), .resp_status_o(resp_status_o),
    .adr_o(adr_o), .dat_o(dat_o), .sel_o(sel_o), .we_o(we_o), .cyc_o(cyc_o),
    .stb_o(stb_o), .lock_o(lock_o), .tga_o(tga_o), .tgc_o(tgc_o), .tgd_o(tgd_o),
    .dat_i(dat_i), .tgd_i(tgd_i), .ack_i(ack_i), .err_i(err_i), .rty_i(rty_i)
  );

  task automatic check_vec(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", tag, act, exp);
    end
  endtask

  // Inputs change and outputs are sampled 1ns after the rising edge.
  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  task automatic do_req(input logic we, input logic lock, input logic [31:0] adr,
                        input logic [31:0] dat, input logic [3:0] sel);
    check_vec("req_ready_idle", 64'(req_ready_o), 64'd1);
    req_we_i = we; req_lock_i = lock; req_adr_i = adr; req_dat_i = dat; req_sel_i = sel;
    req_tga_i = 4'h6; req_tgc_i = 4'h9; req_tgd_i = 4'h3;
    req_valid_i = 1'b1;
    step();
    req_valid_i = 1'b0;
  endtask

  task automatic take_resp();
    check_vec("resp_valid_before_take", 64'(resp_valid_o), 64'd1);
    resp_ready_i = 1'b1;
    step();
    resp_ready_i = 1'b0;
    check_vec("resp_valid_after_take", 64'(resp_valid_o), 64'd0);
    check_vec("req_ready_after_take", 64'(req_ready_o), 64'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, want finish before 200000ns");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_i = 1'b0; req_valid_i = 1'b0; req_we_i = 1'b0; req_lock_i = 1'b0;
    req_adr_i = '0; req_dat_i = '0; req_sel_i = '0; req_tga_i = '0; req_tgc_i = '0;
    req_tgd_i = '0; resp_ready_i = 1'b0; dat_i = '0; tgd_i = '0;
    ack_i = 1'b0; err_i = 1'b0; rty_i = 1'b0;

    // Reset state
    repeat (3) step();
    check_vec("rst_cyc", 64'(cyc_o), 64'd0);
    check_vec("rst_stb", 64'(stb_o), 64'd0);
    check_vec("rst_lock", 64'(lock_o), 64'd0);
    check_vec("rst_we", 64'(we_o), 64'd0);
    check_vec("rst_resp_valid", 64'(resp_valid_o), 64'd0);
    check_vec("rst_status", 64'(resp_status_o), 64'd0);
    check_vec("rst_req_ready", 64'(req_ready_o), 64'd0);
    check_vec("rst_adr", 64'(adr_o), 64'd0);
    rst_i = 1'b1;
    step();

    // Zero-wait read
    do_req(1'b0, 1'b0, 32'h100, 32'h0, 4'hF);
    check_vec("rd_cyc", 64'(cyc_o), 64'd1);
    check_vec("rd_stb", 64'(stb_o), 64'd1);
    check_vec("rd_adr", 64'(adr_o), 64'h100);
    check_vec("rd_tga", 64'(tga_o), 64'h6);
    check_vec("rd_tgc", 64'(tgc_o), 64'h9);
    check_vec("rd_req_ready_busy", 64'(req_ready_o), 64'd0);
    ack_i = 1'b1; dat_i = 32'hDEADBEEF; tgd_i = 4'h5;
    step();
    ack_i = 1'b0; dat_i = '0; tgd_i = '0;
    check_vec("rd_cyc_drop", 64'(cyc_o), 64'd0);
    check_vec("rd_resp_valid_lat2", 64'(resp_valid_o), 64'd1);
    check_vec("rd_resp_dat", 64'(resp_dat_o), 64'hDEADBEEF);
    check_vec("rd_resp_tgd", 64'(resp_tgd_o), 64'h5);
    check_vec("rd_status", 64'(resp_status_o), 64'd0);
    take_resp();

    // Write with three wait states
    do_req(1'b1, 1'b0, 32'h200, 32'h55AA, 4'b0011);
    for (int c = 0; c < 4; c++) begin
      check_vec("wr_cyc", 64'(cyc_o), 64'd1);
      check_vec("wr_dat", 64'(dat_o), 64'h55AA);
      check_vec("wr_sel", 64'(sel_o), 64'h3);
      check_vec("wr_we", 64'(we_o), 64'd1);
      check_vec("wr_tgd", 64'(tgd_o), 64'h3);
      if (c == 3) begin
        ack_i = 1'b1; dat_i = 32'h12345678;
      end
      step();
    end
    ack_i = 1'b0; dat_i = '0;
    check_vec("wr_status", 64'(resp_status_o), 64'd0);
    check_vec("wr_resp_dat_zero", 64'(resp_dat_o), 64'd0);
    take_resp();

    // Locked read, retry exhausted after 4 attempts
    do_req(1'b0, 1'b1, 32'h300, 32'h0, 4'hF);
    for (int a = 0; a < 4; a++) begin
      check_vec("rty_cyc_attempt", 64'(cyc_o), 64'd1);
      check_vec("rty_lock_attempt", 64'(lock_o), 64'd1);
      rty_i = 1'b1;
      step();
      rty_i = 1'b0;
      if (a < 3) begin
        check_vec("rty_gap_cyc", 64'(cyc_o), 64'd0);
        check_vec("rty_gap_lock", 64'(lock_o), 64'd1);
        check_vec("rty_gap_no_resp", 64'(resp_valid_o), 64'd0);
        step();
      end
    end
    check_vec("rty_status", 64'(resp_status_o), 64'd2);
    check_vec("rty_lock_released", 64'(lock_o), 64'd0);
    take_resp();

    // No termination: timeout after exactly 8 bus cycles
    begin
      int n;
      n = 0;
      do_req(1'b0, 1'b0, 32'h400, 32'h0, 4'hF);
      while (cyc_o && n < 50) begin
        n++;
        step();
      end
      check_vec("tmo_cyc_cycles", 64'(n), 64'd8);
      check_vec("tmo_status", 64'(resp_status_o), 64'd3);
      take_resp();
    end

    // err beats ack; response held while resp_ready_i low
    do_req(1'b0, 1'b0, 32'h500, 32'h0, 4'hF);
    err_i = 1'b1; ack_i = 1'b1; dat_i = 32'hFFFF0000;
    step();
    err_i = 1'b0; ack_i = 1'b0; dat_i = '0;
    for (int c = 0; c < 5; c++) begin
      check_vec("err_hold_valid", 64'(resp_valid_o), 64'd1);
      check_vec("err_hold_status", 64'(resp_status_o), 64'd1);
      check_vec("err_hold_req_ready", 64'(req_ready_o), 64'd0);
      check_vec("err_hold_cyc", 64'(cyc_o), 64'd0);
      step();
    end
    take_resp();

    // Reset during the second cycle of a waited read
    do_req(1'b0, 1'b0, 32'h600, 32'h0, 4'hF);
    check_vec("mr_cyc_first", 64'(cyc_o), 64'd1);
    step();
    rst_i = 1'b0;
    step();
    check_vec("mr_cyc_dropped", 64'(cyc_o), 64'd0);
    check_vec("mr_stb_dropped", 64'(stb_o), 64'd0);
    check_vec("mr_no_resp", 64'(resp_valid_o), 64'd0);
    check_vec("mr_req_ready_in_rst", 64'(req_ready_o), 64'd0);
    rst_i = 1'b1;
    step();
    check_vec("mr_no_resp_after", 64'(resp_valid_o), 64'd0);
    do_req(1'b0, 1'b0, 32'h700, 32'h0, 4'hF);
    check_vec("mr_next_adr", 64'(adr_o), 64'h700);
    ack_i = 1'b1; dat_i = 32'hCAFEF00D; tgd_i = 4'hA;
    step();
    ack_i = 1'b0; dat_i = '0; tgd_i = '0;
    check_vec("mr_next_dat", 64'(resp_dat_o), 64'hCAFEF00D);
    check_vec("mr_next_status", 64'(resp_status_o), 64'd0);
    take_resp();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/wb_master_bridge.md
# wb_master_bridge

Wishbone B4 classic-cycle master that converts single-beat processor load/store requests into bus cycles for the peripheral slaves of the multiple-stage hardware model. It sits directly upstream of every peripheral: it drives `adr`/`dat`/`sel`/`we`/`cyc`/`stb`/`lock` and the tag signals, and consumes `ack`/`err`/`rty`/`dat`/`tgd`. It also handles retry, bounded retry count and bus timeout, and returns one status-tagged response per request.

## Interface
Parameters:
- ADDR_WIDTH, default `` `ADDR_WIDTH ``, address width.
- DATA_WIDTH, default `` `DATA_WIDTH ``, data width.
- TGDI_WIDTH / TGDO_WIDTH, default `` `TGDI_WIDTH `` / `` `TGDO_WIDTH ``, slave-to-master / master-to-slave data tag widths.
- TGA_WIDTH, default `` `TGA_WIDTH ``, address tag width.
- TGC_WIDTH, default `` `TGC_WIDTH ``, cycle tag width.
- SEL_WIDTH, default `` `SEL_WIDTH ``, byte-select width.
- MAX_RETRY, default 3, number of `rty` terminations tolerated before failing.
- TIMEOUT, default 255, number of bus cycles allowed without termination.

Ports (one clock; reset is synchronous and active-low):
- clk_i  in  1  clock.
- rst_i  in  1  synchronous, active-low reset.
- req_valid_i  in  1  request valid.
- req_ready_o  out  1  request accepted when high with valid.
- req_we_i  in  1  write request.
- req_lock_i  in  1  request a locked cycle.
- req_adr_i  in  ADDR_WIDTH  request address.
- req_dat_i  in  DATA_WIDTH  write data.
- req_sel_i  in  SEL_WIDTH  byte selects.
- req_tga_i / req_tgc_i / req_tgd_i  in  TGA/TGC/TGDO_WIDTH  request tags.
- resp_valid_o  out  1  response valid.
- resp_ready_i  in  1  response consumed.
- resp_dat_o  out  DATA_WIDTH  read data (captured `dat_i`; 0 for writes).
- resp_tgd_o  out  TGDI_WIDTH  captured `tgd_i`.
- resp_status_o  out  2  status: 00 OK, 01 ERR, 10 RETRY_EXHAUSTED, 11 TIMEOUT.
- adr_o  out  ADDR_WIDTH; dat_o  out  DATA_WIDTH; sel_o  out  SEL_WIDTH; we_o  out  1; cyc_o  out  1; stb_o  out  1; lock_o  out  1; tga_o  out  TGA_WIDTH; tgc_o  out  TGC_WIDTH; tgd_o  out  TGDO_WIDTH — Wishbone master outputs.
- dat_i  in  DATA_WIDTH; tgd_i  in  TGDI_WIDTH; ack_i  in  1; err_i  in  1; rty_i  in  1 — Wishbone slave returns.

## Operation
- FSM states: IDLE, BUS, RETRY_WAIT, RESP.
- **IDLE:** `req_ready_o`=1. On `req_valid_i`, latch all request fields, clear the retry and timeout counters, and go to BUS.
- **BUS:**
  - Outputs: `cyc_o`=`stb_o`=1; `lock_o`=latched lock; all other bus outputs are driven from latched fields.
  - Termination priority is `err_i` > `ack_i` > `rty_i`.
  - `ack_i`: capture `dat_i`/`tgd_i`, status OK, go to RESP.
  - `err_i`: status ERR, go to RESP.
  - `rty_i`: if retry count == MAX_RETRY, status RETRY_EXHAUSTED and go to RESP; otherwise increment the retry count and go to RETRY_WAIT.
  - No termination: increment the timeout counter. When it reaches TIMEOUT, status TIMEOUT and go to RESP.
- **RETRY_WAIT:** exactly one cycle with `cyc_o`=`stb_o`=0, then back to BUS. The timeout counter is cleared on re-entry to BUS. `lock_o` stays high if the request was locked.
- **RESP:** all bus strobes and `lock_o` are 0. `resp_valid_o`=1 and its outputs are held stable until `resp_ready_i`, then go to IDLE.
- Counters:
  - Retry counter width is clog2(MAX_RETRY+1).
  - Timeout counter width is clog2(TIMEOUT+1) and saturates.
- For write responses, `resp_dat_o` is 0.

## Timing
- Reset (`rst_i`=0 at an edge):
  - State → IDLE.
  - `cyc_o`, `stb_o`, `lock_o`, `we_o`, `resp_valid_o` = 0; `resp_status_o`=00; all buses 0.
  - `req_ready_o` is forced 0 while `rst_i` is low.
- Reset mid-operation drops `cyc_o`/`stb_o` at that edge; a pending response is discarded.
- Request accepted at edge N → `cyc_o`/`stb_o` high during cycle N+1.
- Zero-wait slave `ack_i` in cycle N+1 → `resp_valid_o` in cycle N+2. This is the minimum latency of 2.
- `cyc_o`/`stb_o` fall on the same edge that samples the termination; no back-to-back cycles are possible.
- Retry costs 2 cycles (termination plus RETRY_WAIT) per attempt.
- Timeout: with TIMEOUT=T and no termination, `cyc_o` is high for exactly T cycles, then RESP.
- `req_ready_o` is low from acceptance until the cycle after the `resp_ready_i` handshake.

## Structure
- Package `wb_master_pkg` holds:
  - the state enum (IDLE/BUS/RETRY_WAIT/RESP);
  - the status codes `WB_ST_OK`, `WB_ST_ERR`, `WB_ST_RTY`, `WB_ST_TMO`.
- Width macros come from the existing `ripes_params.vh` / `designer_params.vh`.
- One natural sub-module, `wb_retry_timer`, contains the retry and timeout counters with clear/increment/limit outputs. The FSM and latches stay in the top.

## Test plan
- Read `0x100`; slave acks in the first cycle with `0xDEADBEEF` → `cyc_o` high 1 cycle; response `0xDEADBEEF`, status 00, latency 2.
- Write `0x55AA` with sel `0b0011`; slave adds 3 wait states → `dat_o`/`sel_o`/`we_o` stable for 4 cycles; status 00, `resp_dat_o`=0.
- Slave asserts `rty_i` 4 times with MAX_RETRY=3 → 4 bus attempts, 1-cycle gaps, `lock_o` held if locked; status 10.
- Slave never terminates, TIMEOUT=8 → `cyc_o` high exactly 8 cycles; status 11.
- `err_i` and `ack_i` in the same cycle → status 01. Holding `resp_ready_i` low for 5 cycles → response stable; `req_ready_o` low throughout.
- `rst_i` low in the 2nd cycle of a waited read → `cyc_o`/`stb_o` 0 next edge, no `resp_valid_o`; the next request completes normally.
